// File: rtl/neuron_train_sequencer.sv
// neuron_train_sequencer: runs an M-neuron layer through EPOCHS x SAMPLES infer/learn steps; define NEURON_SEQ_EARLY_STOP_EN to end a run at the first error-free epoch
module neuron_train_sequencer #(
  parameter int N       = 16,
  parameter int M       = 8,
  parameter int W       = 8,
  parameter int SETTLE  = 2,
  parameter int SAMPLES = 16,
  parameter int EPOCHS  = 4,
  parameter int TOL     = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                train,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [N-1:0][W-1:0] s_in,
  input  logic [M-1:0][W-1:0] s_expected,
  output logic                layer_valid,
  output logic                layer_learn,
  output logic [N-1:0][W-1:0] layer_in,
  output logic [M-1:0][W-1:0] layer_expected,
  input  logic [M-1:0][W-1:0] layer_out,
  output logic                busy,
  output logic                done,
  output logic [7:0]          epoch,
  output logic [15:0]         sample_idx,
  output logic [15:0]         err_count,
  output logic [15:0]         last_err
);
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] FETCH    = 4'd1;
  localparam logic [3:0] INFER    = 4'd2;
  localparam logic [3:0] SETTLE_I = 4'd3;
  localparam logic [3:0] EVAL     = 4'd4;
  localparam logic [3:0] LEARN    = 4'd5;
  localparam logic [3:0] SETTLE_L = 4'd6;
  localparam logic [3:0] NEXT     = 4'd7;
  localparam logic [3:0] FIN      = 4'd8;
  localparam int CW = $clog2(M + 1);
  localparam logic [W-1:0] TOL_W = W'(TOL);

  logic [3:0]           state_q, state_d, cnt_q, cnt_d;
  logic                 train_q, train_d;
  logic [7:0]           epoch_q, epoch_d;
  logic [15:0]          idx_q, idx_d, err_q, err_d, last_q, last_d;
  logic [N-1:0][W-1:0]  in_q, in_d;
  logic [M-1:0][W-1:0]  exp_q, exp_d;
  logic [W-1:0]         diff;
  logic [CW-1:0]        miss;
  logic [16:0]          sum;
  logic [15:0]          err_sat;
  logic                 settled, last_sample, stop;

  assign s_ready        = state_q == FETCH;
  assign layer_valid    = state_q == INFER || state_q == LEARN;
  assign layer_learn    = state_q == LEARN;
  assign busy           = state_q != IDLE;
  assign done           = state_q == FIN;
  assign layer_in       = in_q;
  assign layer_expected = exp_q;
  assign epoch          = epoch_q;
  assign sample_idx     = idx_q;
  assign err_count      = err_q;
  assign last_err       = last_q;

  assign settled     = cnt_q == 4'(SETTLE - 1);
  assign last_sample = idx_q == 16'(SAMPLES - 1);
`ifdef NEURON_SEQ_EARLY_STOP_EN
  assign stop = epoch_q == 8'(EPOCHS - 1) || err_q == '0;
`else
  assign stop = epoch_q == 8'(EPOCHS - 1);
`endif

  // count neurons whose unsigned distance from the target exceeds the tolerance
  always_comb begin
    miss = '0;
    diff = '0;
    for (int k = 0; k < M; k++) begin
      diff = layer_out[k] > exp_q[k] ? layer_out[k] - exp_q[k] : exp_q[k] - layer_out[k];
      miss = miss + CW'(diff > TOL_W);
    end
  end

  assign sum     = {1'b0, err_q} + 17'(miss);
  assign err_sat = sum[16] ? 16'hFFFF : sum[15:0];

  // next-state and counter updates for the sample/epoch sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    train_d = train_q;
    epoch_d = epoch_q;
    idx_d   = idx_q;
    err_d   = err_q;
    last_d  = last_q;
    in_d    = in_q;
    exp_d   = exp_q;
    case (state_q)
      IDLE: if (start) begin
        train_d = train;
        epoch_d = '0;
        idx_d   = '0;
        err_d   = '0;
        state_d = FETCH;
      end
      FETCH: if (s_valid) begin
        in_d    = s_in;
        exp_d   = s_expected;
        state_d = INFER;
      end
      INFER: begin
        cnt_d   = '0;
        state_d = SETTLE_I;
      end
      SETTLE_I: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = settled ? EVAL : SETTLE_I;
      end
      EVAL: begin
        err_d   = err_sat;
        state_d = train_q ? LEARN : NEXT;
      end
      LEARN: begin
        cnt_d   = '0;
        state_d = SETTLE_L;
      end
      SETTLE_L: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = settled ? NEXT : SETTLE_L;
      end
      NEXT: if (last_sample) begin
        last_d  = err_q;
        err_d   = '0;
        idx_d   = '0;
        epoch_d = stop ? epoch_q : epoch_q + 8'd1;
        state_d = stop ? FIN : FETCH;
      end else begin
        idx_d   = idx_q + 16'd1;
        state_d = FETCH;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // register bank; reset drops strobes and clears every output at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      train_q <= 1'b0;
      epoch_q <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      last_q  <= '0;
      in_q    <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      train_q <= train_d;
      epoch_q <= epoch_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      last_q  <= last_d;
      in_q    <= in_d;
      exp_q   <= exp_d;
    end
  end
endmodule
